// File: rtl/sys_defs.sv
// Shared machine-wide definitions: datapath width, ROB sizing, ROB entry and commit packet.
// No logic; types only.
// Imported by the reorder buffer and commit_stage so both agree on entry layout.
package sys_defs;

  localparam int XLEN      = 32;
  localparam int ROB_SIZE  = 16;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);

  // One in-flight instruction as held in the ROB.
  typedef struct packed {
    logic            valid;
    logic            ready;
    logic            wr_mem;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] value;
  } ROB_ENTRY;

  // What commit_stage hands onward once an entry retires.
  typedef struct packed {
    logic            valid;
    logic            wr_mem;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] value;
  } COMMIT_PACKET;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete via CDB, in-order retire.
// Outputs are combinational from registered state only; a CDB completion shows on head_ready next cycle.
// Dispatch must stall on rob_full (dropped otherwise); commit never back-pressures; squash beats everything.
module reorder_buffer
  import sys_defs::*;
#(
  parameter int  ROB_SIZE = sys_defs::ROB_SIZE,
  localparam int IDX_W    = $clog2(ROB_SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_valid,
  input  ROB_ENTRY         dispatch_entry,
  output logic [IDX_W-1:0] dispatch_idx,
  output logic             rob_full,
  output logic [IDX_W:0]   rob_count,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_idx,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             squash,
  output ROB_ENTRY         head_entry,
  output logic             head_ready
);

  ROB_ENTRY         entries_q [ROB_SIZE];
  ROB_ENTRY         entries_d [ROB_SIZE];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             rob_empty;
  logic             dispatch_accept;
  ROB_ENTRY         new_entry;

  // Count disambiguates full from empty when head and tail coincide.
  assign rob_empty       = (count_q == '0);
  assign rob_full        = (count_q == (IDX_W+1)'(ROB_SIZE));
  assign rob_count       = count_q;
  assign dispatch_idx    = tail_q;
  assign head_ready      = entries_q[head_q].valid & entries_q[head_q].ready & ~rob_empty;
  assign head_entry      = rob_empty ? '0 : entries_q[head_q];
  // Full is judged on registered count, so a same-cycle retire does not free a slot for dispatch.
  assign dispatch_accept = dispatch_valid & ~rob_full & ~squash;

  // Next-state for entries and pointers: squash overrides; otherwise complete, retire, then allocate.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    new_entry       = dispatch_entry;
    new_entry.valid = 1'b1;
    new_entry.ready = 1'b0;
    new_entry.value = '0;

    if (squash) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // A CDB tag that names a free slot is stale and must not mark anything.
      if (cdb_valid && entries_q[cdb_idx].valid) begin
        entries_d[cdb_idx].ready = 1'b1;
        entries_d[cdb_idx].value = cdb_value;
      end
      if (head_ready) begin
        entries_d[head_q].valid = 1'b0;
        head_d                  = head_q + IDX_W'(1);
      end
      // The tail slot is never occupied when not full, so allocation cannot clobber live state.
      if (dispatch_accept) begin
        entries_d[tail_q] = new_entry;
        tail_d            = tail_q + IDX_W'(1);
      end
      count_d = count_q + (IDX_W+1)'(dispatch_accept) - (IDX_W+1)'(head_ready);
    end
  end

  // State registers; the entry array needs async clear so it stays in flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for basic allocate/complete/retire,
// hand sequences for reset, full, squash, wrap and full-with-retire corners.
// Expected values are hand-derived; the streaming test uses a pc scoreboard.
module tb_reorder_buffer;
  import sys_defs::*;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            dispatch_valid = 1'b0;
  ROB_ENTRY        dispatch_entry = '0;
  logic [3:0]      dispatch_idx;
  logic            rob_full;
  logic [4:0]      rob_count;
  logic            cdb_valid = 1'b0;
  logic [3:0]      cdb_idx = '0;
  logic [XLEN-1:0] cdb_value = '0;
  logic            squash = 1'b0;
  ROB_ENTRY        head_entry;
  logic            head_ready;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.ROB_SIZE(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dispatch_entry (dispatch_entry),
    .dispatch_idx   (dispatch_idx),
    .rob_full       (rob_full),
    .rob_count      (rob_count),
    .cdb_valid      (cdb_valid),
    .cdb_idx        (cdb_idx),
    .cdb_value      (cdb_value),
    .squash         (squash),
    .head_entry     (head_entry),
    .head_ready     (head_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        dv;
    logic [4:0]  dest;
    logic        cv;
    logic [3:0]  ci;
    logic [31:0] cval;
    logic [4:0]  cnt;
    logic        full;
    logic [3:0]  idx;
    logic        hr;
    logic        hv;
    logic [4:0]  hdest;
    logic [31:0] hval;
  } vec_t;

  vec_t tbl[18];
  int   sb_q[$];
  int   retired;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [4:0] dest, input logic [31:0] pc,
                       input logic cv, input logic [3:0] ci, input logic [31:0] cval,
                       input logic sq);
    dispatch_valid          = dv;
    dispatch_entry          = '0;
    dispatch_entry.dest_reg = dest;
    dispatch_entry.pc       = pc;
    cdb_valid               = cv;
    cdb_idx                 = ci;
    cdb_value               = cval;
    squash                  = sq;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  initial begin
    // dv dest cv ci cval | cnt full idx hr hv hdest hval
    tbl[0]  = '{1'b1, 5'd1, 1'b0, 4'd0, 32'h00, 5'd1, 1'b0, 4'd1, 1'b0, 1'b1, 5'd1, 32'h00};
    tbl[1]  = '{1'b1, 5'd2, 1'b0, 4'd0, 32'h00, 5'd2, 1'b0, 4'd2, 1'b0, 1'b1, 5'd1, 32'h00};
    tbl[2]  = '{1'b1, 5'd3, 1'b0, 4'd0, 32'h00, 5'd3, 1'b0, 4'd3, 1'b0, 1'b1, 5'd1, 32'h00};
    tbl[3]  = '{1'b0, 5'd0, 1'b1, 4'd1, 32'hAA, 5'd3, 1'b0, 4'd3, 1'b0, 1'b1, 5'd1, 32'h00};
    tbl[4]  = '{1'b0, 5'd0, 1'b1, 4'd0, 32'h55, 5'd3, 1'b0, 4'd3, 1'b1, 1'b1, 5'd1, 32'h55};
    tbl[5]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 5'd2, 1'b0, 4'd3, 1'b1, 1'b1, 5'd2, 32'hAA};
    tbl[6]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 5'd1, 1'b0, 4'd3, 1'b0, 1'b1, 5'd3, 32'h00};
    tbl[7]  = '{1'b0, 5'd0, 1'b1, 4'd2, 32'h77, 5'd1, 1'b0, 4'd3, 1'b1, 1'b1, 5'd3, 32'h77};
    tbl[8]  = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 5'd0, 1'b0, 4'd3, 1'b0, 1'b0, 5'd0, 32'h00};
    tbl[9]  = '{1'b0, 5'd0, 1'b1, 4'd5, 32'h99, 5'd0, 1'b0, 4'd3, 1'b0, 1'b0, 5'd0, 32'h00};
    tbl[10] = '{1'b1, 5'd9, 1'b1, 4'd3, 32'h33, 5'd1, 1'b0, 4'd4, 1'b0, 1'b1, 5'd9, 32'h00};
    tbl[11] = '{1'b0, 5'd0, 1'b1, 4'd3, 32'h44, 5'd1, 1'b0, 4'd4, 1'b1, 1'b1, 5'd9, 32'h44};
    tbl[12] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 5'd0, 1'b0, 4'd4, 1'b0, 1'b0, 5'd0, 32'h00};
    tbl[13] = '{1'b1, 5'd4, 1'b0, 4'd0, 32'h00, 5'd1, 1'b0, 4'd5, 1'b0, 1'b1, 5'd4, 32'h00};
    tbl[14] = '{1'b0, 5'd0, 1'b1, 4'd4, 32'h10, 5'd1, 1'b0, 4'd5, 1'b1, 1'b1, 5'd4, 32'h10};
    tbl[15] = '{1'b1, 5'd5, 1'b0, 4'd0, 32'h00, 5'd1, 1'b0, 4'd6, 1'b0, 1'b1, 5'd5, 32'h00};
    tbl[16] = '{1'b0, 5'd0, 1'b1, 4'd5, 32'h20, 5'd1, 1'b0, 4'd6, 1'b1, 1'b1, 5'd5, 32'h20};
    tbl[17] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'h00, 5'd0, 1'b0, 4'd6, 1'b0, 1'b0, 5'd0, 32'h00};

    #2;
    chk("reset_count", rob_count, 5'd0);
    chk("reset_head_ready", head_ready, 1'b0);
    #10 reset = 1'b0;

    // Allocate, out-of-order complete, in-order retire, stale CDB, same-cycle retire+dispatch.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].dv, tbl[i].dest, {27'd0, tbl[i].dest}, tbl[i].cv, tbl[i].ci, tbl[i].cval, 1'b0);
      tick();
      chk($sformatf("v%0d_count", i), rob_count, tbl[i].cnt);
      chk($sformatf("v%0d_full", i), rob_full, tbl[i].full);
      chk($sformatf("v%0d_idx", i), dispatch_idx, tbl[i].idx);
      chk($sformatf("v%0d_head_ready", i), head_ready, tbl[i].hr);
      chk($sformatf("v%0d_head_valid", i), head_entry.valid, tbl[i].hv);
      chk($sformatf("v%0d_head_dest", i), head_entry.dest_reg, tbl[i].hdest);
      chk($sformatf("v%0d_head_value", i), head_entry.value, tbl[i].hval);
    end

    // Asynchronous reset away from any clock edge clears outputs at once.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i), 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", rob_count, 5'd0);
    chk("async_rst_full", rob_full, 1'b0);
    chk("async_rst_idx", dispatch_idx, 4'd0);
    chk("async_rst_head_ready", head_ready, 1'b0);
    chk("async_rst_head_valid", head_entry.valid, 1'b0);
    #2 reset = 1'b0;

    // Fill to capacity; the 17th dispatch is dropped.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i), 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    chk("fill_count", rob_count, 5'd16);
    chk("fill_full", rob_full, 1'b1);
    chk("fill_idx", dispatch_idx, 4'd0);
    drive(1'b1, 5'd30, 32'd99, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    chk("over_count", rob_count, 5'd16);
    chk("over_idx", dispatch_idx, 4'd0);
    chk("over_head_dest", head_entry.dest_reg, 5'd1);

    // Full ROB with ready head: dispatch rejected, head retires, one slot frees next cycle.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 4'd0, 32'hBEEF, 1'b0);
    tick();
    chk("fullret_ready", head_ready, 1'b1);
    chk("fullret_full_before", rob_full, 1'b1);
    drive(1'b1, 5'd31, 32'd77, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    chk("fullret_count", rob_count, 5'd15);
    chk("fullret_full", rob_full, 1'b0);
    chk("fullret_idx", dispatch_idx, 4'd0);
    chk("fullret_head_dest", head_entry.dest_reg, 5'd2);

    // Squash with five in flight and a same-cycle dispatch and CDB.
    drive(1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
    tick();
    chk("sq0_count", rob_count, 5'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i), 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 4'd0, 32'h11, 1'b0);
    tick();
    chk("sq_pre_ready", head_ready, 1'b1);
    chk("sq_pre_count", rob_count, 5'd5);
    drive(1'b1, 5'd20, 32'd50, 1'b1, 4'd1, 32'h22, 1'b1);
    tick();
    chk("sq_count", rob_count, 5'd0);
    chk("sq_head_ready", head_ready, 1'b0);
    chk("sq_idx", dispatch_idx, 4'd0);
    chk("sq_head_valid", head_entry.valid, 1'b0);
    idle();
    tick();
    chk("sq_idle_count", rob_count, 5'd0);
    drive(1'b1, 5'd7, 32'd7, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    chk("sq_redisp_count", rob_count, 5'd1);
    chk("sq_redisp_idx", dispatch_idx, 4'd1);
    chk("sq_redisp_dest", head_entry.dest_reg, 5'd7);
    chk("sq_redisp_ready", head_ready, 1'b0);

    // Streaming 40 instructions: tags wrap, retire order matches dispatch order.
    idle();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    retired = 0;
    for (int i = 0; i < 46; i++) begin
      drive(i < 40, 5'(i), 32'(i), (i > 0) && (i <= 40), 4'((i - 1) % 16), 32'(i - 1 + 'h100), 1'b0);
      if (i < 40) sb_q.push_back(i);
      tick();
      chk($sformatf("stream%0d_count_le16", i), rob_count <= 5'd16, 1'b1);
      if (head_ready) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("stream%0d_spurious_retire", i), 1'b1, 1'b0);
        end else begin
          chk($sformatf("stream%0d_pc", i), head_entry.pc, sb_q[0]);
          chk($sformatf("stream%0d_val", i), head_entry.value, sb_q[0] + 'h100);
          void'(sb_q.pop_front());
          retired++;
        end
      end
    end
    chk("stream_retired", retired, 40);
    chk("stream_idx_wrap", dispatch_idx, 4'd8);
    chk("stream_drained", rob_count, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
